// File: rtl/i2c_codec_target_pkg.sv
// Shared definitions for the WM8731-style codec control-port target:
// register addresses, power-on defaults, device address and FSM states.
package i2c_codec_target_pkg;

  localparam logic [6:0] DEV_ADDR_WM8731 = 7'h1A;

  localparam logic [6:0] REG_R0    = 7'h00;
  localparam logic [6:0] REG_R1    = 7'h01;
  localparam logic [6:0] REG_R2    = 7'h02;
  localparam logic [6:0] REG_R3    = 7'h03;
  localparam logic [6:0] REG_R4    = 7'h04;
  localparam logic [6:0] REG_R5    = 7'h05;
  localparam logic [6:0] REG_R6    = 7'h06;
  localparam logic [6:0] REG_R7    = 7'h07;
  localparam logic [6:0] REG_R8    = 7'h08;
  localparam logic [6:0] REG_R9    = 7'h09;
  localparam logic [6:0] REG_RESET = 7'h0F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEVADDR,
    ST_ACK_DEV,
    ST_BYTE1,
    ST_ACK1,
    ST_BYTE2,
    ST_ACK2,
    ST_IGNORE
  } i2c_state_e;

  // Power-on / reset-register value of each implemented codec register.
  function automatic logic [8:0] reg_default(input logic [6:0] addr);
    case (addr)
      REG_R0:  return 9'h097;
      REG_R1:  return 9'h097;
      REG_R2:  return 9'h079;
      REG_R3:  return 9'h079;
      REG_R4:  return 9'h00A;
      REG_R5:  return 9'h008;
      REG_R6:  return 9'h09F;
      REG_R7:  return 9'h00A;
      REG_R8:  return 9'h000;
      REG_R9:  return 9'h000;
      default: return 9'h000;
    endcase
  endfunction

endpackage

// File: rtl/i2c_codec_target_bus_sampler.sv
// Bus sampler: synchronises SCL/SDA into the clk domain and derives
// SCL edges plus START/STOP conditions from the last two synchronised samples.
// SYNC_STAGES must be at least 2.
module i2c_codec_target_bus_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic sda_bit_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_now;
  logic                   sda_now;

  // Synchroniser chains preset high so reset looks like an idle bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  // SDA moving while SCL is held high is a bus condition, never data.
  always_comb begin
    scl_now    = scl_sync_q[SYNC_STAGES-1];
    sda_now    = sda_sync_q[SYNC_STAGES-1];
    scl_rise_o = scl_now & ~scl_prev_q;
    scl_fall_o = ~scl_now & scl_prev_q;
    sda_bit_o  = sda_now;
    start_o    = scl_now & scl_prev_q & sda_prev_q & ~sda_now;
    stop_o     = scl_now & scl_prev_q & ~sda_prev_q & sda_now;
  end

endmodule

// File: rtl/i2c_codec_target.sv
// I2C target emulating the WM8731 codec control port: accepts 3-byte write
// frames, ACKs them, commits writes into a shadow register file and exposes
// readback plus decoded codec state.
module i2c_codec_target
  import i2c_codec_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_WM8731,
  parameter int         SYNC_STAGES = 2,
  parameter int         NUM_REGS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_in,
  output logic       i2c_sdat_oe,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       codec_active,
  output logic       unmapped
);

  logic scl_rise;
  logic scl_fall;
  logic sda_bit;
  logic start;
  logic stop;

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_phase_q, ack_phase_d;
  logic       oe_q, oe_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic       d8_q, d8_d;
  logic       wr_valid_q, wr_valid_d;
  logic [8:0] wr_data_q, wr_data_d;
  logic       unmapped_q, unmapped_d;
  logic [7:0] byte_w;
  logic       commit;
  logic       addr_mapped;

  logic [8:0] regs_q [NUM_REGS];

  i2c_codec_target_bus_sampler #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk_i     (clk),
    .rst_i     (rst),
    .scl_i     (i2c_sclk),
    .sda_i     (i2c_sdat_in),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .sda_bit_o (sda_bit),
    .start_o   (start),
    .stop_o    (stop)
  );

  // Frame state register; a reset mid-frame drops everything and releases SDA.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ack_phase_q <= 1'b0;
      oe_q        <= 1'b0;
      wr_addr_q   <= '0;
      d8_q        <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_data_q   <= '0;
      unmapped_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ack_phase_q <= ack_phase_d;
      oe_q        <= oe_d;
      wr_addr_q   <= wr_addr_d;
      d8_q        <= d8_d;
      wr_valid_q  <= wr_valid_d;
      wr_data_q   <= wr_data_d;
      unmapped_q  <= unmapped_d;
    end
  end

  // Next-state logic: START/STOP override everything, otherwise shift bytes
  // on SCL rises and run the two-falling-edge ACK window in the ACK states.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ack_phase_d = ack_phase_q;
    oe_d        = oe_q;
    wr_addr_d   = wr_addr_q;
    d8_d        = d8_q;
    commit      = 1'b0;
    byte_w      = {shift_q[6:0], sda_bit};

    if (start) begin
      state_d     = ST_DEVADDR;
      cnt_d       = '0;
      ack_phase_d = 1'b0;
      oe_d        = 1'b0;
    end else if (stop) begin
      state_d     = ST_IDLE;
      ack_phase_d = 1'b0;
      oe_d        = 1'b0;
    end else begin
      case (state_q)
        ST_DEVADDR, ST_BYTE1, ST_BYTE2: begin
          if (scl_rise) begin
            shift_d = byte_w;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              case (state_q)
                ST_DEVADDR: state_d = (byte_w == {DEV_ADDR, 1'b0}) ? ST_ACK_DEV : ST_IGNORE;
                ST_BYTE1: begin
                  wr_addr_d = byte_w[7:1];
                  d8_d      = byte_w[0];
                  state_d   = ST_ACK1;
                end
                default: state_d = ST_ACK2;
              endcase
            end
          end
        end
        ST_ACK_DEV, ST_ACK1, ST_ACK2: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              oe_d        = 1'b1;
              ack_phase_d = 1'b1;
              commit      = (state_q == ST_ACK2);
            end else begin
              oe_d        = 1'b0;
              ack_phase_d = 1'b0;
              case (state_q)
                ST_ACK_DEV: state_d = ST_BYTE1;
                ST_ACK1:    state_d = ST_BYTE2;
                default:    state_d = ST_IGNORE;
              endcase
            end
          end
        end
        default: ;
      endcase
    end

    addr_mapped = (32'(wr_addr_q) < NUM_REGS) || (wr_addr_q == REG_RESET);
    wr_valid_d  = commit;
    wr_data_d   = commit ? {d8_q, shift_q} : wr_data_q;
    unmapped_d  = commit & ~addr_mapped;
  end

  // Shadow register file, updated the cycle after the write is announced.
  always_ff @(posedge clk) begin
    if (rst || (wr_valid_q && wr_addr_q == REG_RESET)) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(7'(i));
    end else if (wr_valid_q) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_addr_q == 7'(i)) regs_q[i] <= wr_data_q;
      end
    end
  end

  // Combinational readback; unimplemented addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 4'(i)) rd_data = regs_q[i];
    end
  end

  assign i2c_sdat_oe  = oe_q;
  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign unmapped     = unmapped_q;
  assign codec_active = regs_q[9][0];

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: an I2C master model drives write frames,
// a reference model predicts commits (scoreboard queue) and register contents.
module tb_i2c_codec_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sdat_oe;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic [3:0] rd_addr = 4'd0;
  logic [8:0] rd_data;
  logic       codec_active;
  logic       unmapped;

  typedef struct {
    logic [6:0] addr;
    logic [8:0] data;
    logic       unm;
  } wr_exp_t;

  wr_exp_t    expQ[$];
  wr_exp_t    expItem;
  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] modelRegs [16];
  logic [8:0] resetVals [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  logic [7:0] txBytes [8];
  int         txLen;

  always #5 clk = ~clk;

  // Open-drain bus: either side may pull SDA low.
  assign sda_line = sda_m & ~sdat_oe;

  i2c_codec_target dut (
    .clk         (clk),
    .rst         (rst),
    .i2c_sclk    (sclk),
    .i2c_sdat_in (sda_line),
    .i2c_sdat_oe (sdat_oe),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .codec_active(codec_active),
    .unmapped    (unmapped)
  );

  // Monitor: every committed write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_write: got addr=%h data=%h, required none", wr_addr, wr_data);
        end else begin
          expItem = expQ.pop_front();
          if (wr_addr !== expItem.addr || wr_data !== expItem.data || unmapped !== expItem.unm) begin
            miscompares++;
            $display("[TB] FAIL write: got addr=%h data=%h unm=%b, required addr=%h data=%h unm=%b",
                     wr_addr, wr_data, unmapped, expItem.addr, expItem.data, expItem.unm);
          end
        end
      end else if (unmapped) begin
        miscompares++;
        $display("[TB] FAIL unmapped_alone: got 1, required 0 without wr_valid");
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2cStart();
    sda_m = 1'b1; waitClk(5);
    sclk  = 1'b1; waitClk(10);
    sda_m = 1'b0; waitClk(10);
    sclk  = 1'b0; waitClk(5);
  endtask

  task automatic i2cStop();
    sda_m = 1'b0; waitClk(5);
    sclk  = 1'b1; waitClk(10);
    sda_m = 1'b1; waitClk(10);
  endtask

  task automatic i2cWriteByte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; waitClk(5);
      sclk  = 1'b1; waitClk(10);
      sclk  = 1'b0; waitClk(5);
    end
    sda_m = 1'b1; waitClk(5);
    sclk  = 1'b1; waitClk(5);
    #1 ack = ~sda_line;
    waitClk(5);
    sclk  = 1'b0; waitClk(5);
  endtask

  task automatic loadFrame(input int n, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    txLen = n;
    txBytes[0] = a;
    txBytes[1] = b;
    txBytes[2] = c;
  endtask

  // Reference model: an addressed frame of three or more bytes is one write.
  task automatic modelWrite(input logic [6:0] addr, input logic [8:0] data);
    logic unm;
    unm = !((addr < 7'd10) || (addr == 7'h0F));
    expQ.push_back('{addr, data, unm});
    if (addr < 7'd10) modelRegs[addr[3:0]] = data;
    else if (addr == 7'h0F) for (int i = 0; i < 10; i++) modelRegs[i] = resetVals[i];
  endtask

  // Send the loaded frame, checking each ACK bit against the model.
  task automatic applyStimulus(input bit endStop);
    logic ack;
    logic expAck;
    bit   devOk;
    devOk = (txBytes[0] == 8'h34);
    if (devOk && txLen >= 3) modelWrite(txBytes[1][7:1], {txBytes[1][0], txBytes[2]});
    i2cStart();
    for (int k = 0; k < txLen; k++) begin
      i2cWriteByte(txBytes[k], ack);
      expAck = devOk && (k < 3);
      vectors++;
      if (ack !== expAck) begin
        miscompares++;
        $display("[TB] FAIL ack byte%0d (%h): got %b, required %b", k, txBytes[k], ack, expAck);
      end
    end
    if (endStop) i2cStop();
    waitClk(6);
  endtask

  // Compare every readback address and codec_active with the model.
  task automatic checkOutput();
    logic [8:0] expv;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      expv = (a < 10) ? modelRegs[a] : 9'h000;
      vectors++;
      if (rd_data !== expv) begin
        miscompares++;
        $display("[TB] FAIL rd_data[%0d]: got %h, required %h", a, rd_data, expv);
      end
    end
    vectors++;
    if (codec_active !== modelRegs[9][0]) begin
      miscompares++;
      $display("[TB] FAIL codec_active: got %b, required %b", codec_active, modelRegs[9][0]);
    end
    waitClk(1);
  endtask

  initial begin
    logic [7:0] b0;
    for (int i = 0; i < 16; i++) modelRegs[i] = (i < 10) ? resetVals[i] : 9'h000;
    waitClk(5);
    rst = 1'b0;
    waitClk(2);

    vectors++;
    if ({sdat_oe, wr_valid, unmapped, wr_addr, wr_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got oe=%b v=%b u=%b a=%h d=%h, required all 0",
               sdat_oe, wr_valid, unmapped, wr_addr, wr_data);
    end
    checkOutput();

    loadFrame(3, 8'h34, 8'h04, 8'hE2); applyStimulus(1'b1); checkOutput();
    loadFrame(3, 8'h34, 8'h12, 8'h01); applyStimulus(1'b1); checkOutput();
    loadFrame(3, 8'h34, 8'h12, 8'h00); applyStimulus(1'b1); checkOutput();
    loadFrame(3, 8'h36, 8'h04, 8'hE2); applyStimulus(1'b1); checkOutput();
    loadFrame(3, 8'h34, 8'h08, 8'h12); applyStimulus(1'b1); checkOutput();
    loadFrame(3, 8'h34, 8'h1E, 8'h00); applyStimulus(1'b1); checkOutput();
    loadFrame(2, 8'h34, 8'h04, 8'h00); applyStimulus(1'b1); checkOutput();
    loadFrame(2, 8'h34, 8'h04, 8'h00); applyStimulus(1'b0);
    loadFrame(3, 8'h34, 8'h06, 8'hE2); applyStimulus(1'b1); checkOutput();
    loadFrame(3, 8'h34, 8'h14, 8'h55); applyStimulus(1'b1); checkOutput();
    loadFrame(1, 8'h35, 8'h00, 8'h00); applyStimulus(1'b1); checkOutput();

    loadFrame(4, 8'h34, 8'h0A, 8'h3C);
    txBytes[3] = 8'hA5;
    applyStimulus(1'b1); checkOutput();

    for (int n = 0; n < 16; n++) begin
      b0 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h34;
      loadFrame(3, b0, 8'($urandom), 8'($urandom));
      applyStimulus($urandom_range(0, 1) == 1);
      checkOutput();
    end
    i2cStop();
    waitClk(10);

    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL pending_writes: got %0d outstanding, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
